mtr_pwm_gen: RTL

Complementary PWM generator producing the raw high-side/low-side gate requests for both half-bridges of one motor: forward (`fwd_*`) and reverse (`rev_*`). Each of its four drive outputs feeds a non-overlap stage, which inserts dead time before the gate drivers. The block takes a signed duty command over a valid/ready handshake, double-buffers it, and applies it only at period boundaries. It also provides enable (coast) and brake control.

---
 rtl/mtr_pwm_gen_pkg.sv | 29 ++
 rtl/mtr_pwm_gen_cnt_cmp.sv | 33 +++
 rtl/mtr_pwm_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mtr_pwm_gen_pkg.sv
// Shared types and helpers for the motor PWM generator.
// Holds the FSM state encoding, the drive bundle type and the saturating magnitude function.
package mtr_pwm_pkg;

  localparam int CNT_W_DFLT = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2
  } pwm_st_t;

  typedef struct packed {
    logic fwd_high;
    logic fwd_low;
    logic rev_high;
    logic rev_low;
  } drv_t;

  // |d| clamped to 2^w-1; only the most-negative command actually needs the clamp
  function automatic int unsigned sat_mag(input int d, input int unsigned w);
    int unsigned lim;
    int unsigned a;
    lim = (32'd1 << w) - 32'd1;
    a   = (d < 0) ? unsigned'(-d) : unsigned'(d);
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/mtr_pwm_gen_cnt_cmp.sv
// Free-running PWM period counter with wrap flag and combinational on-time compare.
// Counts only while adv is high; clr dominates and parks the count at zero.
module pwm_cnt_cmp
  import mtr_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [CNT_W-1:0] mag,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             on
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign wrap = adv & (cnt == CNT_MAX);
  assign on   = (cnt < mag);

endmodule

// File: rtl/mtr_pwm_gen.sv
// Complementary PWM for both half-bridges with double-buffered signed duty, brake and coast.
// Outputs registered one cycle after the count; duty_rdy low while a command waits for the period wrap.
module mtr_pwm_gen
  import mtr_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [CNT_W:0] duty,
  input  logic               duty_vld,
  output logic               duty_rdy,
  input  logic               en,
  input  logic               brake,
  output logic               fwd_high,
  output logic               fwd_low,
  output logic               rev_high,
  output logic               rev_low,
  output logic               prd_strt,
  output logic               sat
);

  pwm_st_t              state;
  pwm_st_t              state_nxt;
  logic signed [CNT_W:0] act_duty;
  logic signed [CNT_W:0] pend_duty;
  logic                 pend_full;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     mag;
  logic                 wrap;
  logic                 on;
  logic                 xfer;
  logic                 load;
  logic                 cnt_clr;
  logic                 cnt_adv;
  logic signed [31:0]   duty_ext;
  drv_t                 drv_q;
  drv_t                 drv_nxt;
  logic                 prd_nxt;

  assign duty_rdy = ~pend_full;
  assign xfer     = duty_vld & ~pend_full;

  // Counter is parked at zero in IDLE and on the cycle en drops
  assign cnt_clr = (state == IDLE) | ~en;
  assign cnt_adv = ~cnt_clr;

  // Pending command moves to active at a wrap, or on the IDLE->RUN entry cycle
  assign load = pend_full & (wrap | ((state == IDLE) & en));

  assign duty_ext = {{(31-CNT_W){act_duty[CNT_W]}}, act_duty};
  assign mag      = CNT_W'(sat_mag(duty_ext, CNT_W));

  pwm_cnt_cmp #(
    .CNT_W (CNT_W)
  ) u_cnt_cmp (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .adv   (cnt_adv),
    .mag   (mag),
    .cnt   (cnt),
    .wrap  (wrap),
    .on    (on)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en)        state_nxt = IDLE;
        else if (brake) state_nxt = BRAKE;
      end
      BRAKE: begin
        if (!en)                state_nxt = IDLE;
        else if (wrap && !brake) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drive for the current count; en and brake act on this cycle so their effect lands next cycle
  always_comb begin
    drv_nxt = '0;
    prd_nxt = 1'b0;
    if ((state != IDLE) && en) begin
      prd_nxt = (cnt == '0);
      if ((state == BRAKE) || brake) begin
        drv_nxt.fwd_low = 1'b1;
        drv_nxt.rev_low = 1'b1;
      end else if (act_duty[CNT_W]) begin
        drv_nxt.rev_high = on;
        drv_nxt.rev_low  = ~on;
        drv_nxt.fwd_low  = 1'b1;
      end else begin
        drv_nxt.fwd_high = on;
        drv_nxt.fwd_low  = ~on;
        drv_nxt.rev_low  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      act_duty  <= '0;
      pend_duty <= '0;
      pend_full <= 1'b0;
      drv_q     <= '0;
      prd_strt  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_full <= xfer | (pend_full & ~load);
      if (xfer) pend_duty <= duty;
      if (load) act_duty <= pend_duty;
      drv_q     <= drv_nxt;
      prd_strt  <= prd_nxt;
      sat       <= act_duty[CNT_W] & ~(|act_duty[CNT_W-1:0]);
    end
  end

  assign fwd_high = drv_q.fwd_high;
  assign fwd_low  = drv_q.fwd_low;
  assign rev_high = drv_q.rev_high;
  assign rev_low  = drv_q.rev_low;

endmodule
